spi_reg_bank: RTL



---
 rtl/spi_pkg.sv | 34 +++
 rtl/spi_sync_edge.sv | 36 +++
 rtl/spi_reg_bank.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state type and frame-layout helpers for spi_reg_bank.
// Frames are shifted in MSB first: R/W flag, then address, then data.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Value of the leading frame bit that marks a write.
    localparam logic RW_WRITE = 1'b1;

    // Total frame length in SCLK bits.
    function automatic int frame_bits(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

    // Bit index of the R/W flag inside a completely received frame.
    function automatic int rw_pos(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

    // Bit index of the address LSB inside a completely received frame.
    function automatic int addr_lsb(input int data_w);
        return data_w;
    endfunction

    // Number of bits in the R/W + address header.
    function automatic int hdr_bits(input int addr_w);
        return 1 + addr_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: two-flop synchroniser for one asynchronous pin followed by an
// edge-detect flop. RESET_VAL is the pin's idle level, so leaving reset never
// shows a spurious edge while the pin sits at that level.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_p0;
    logic sync_p1;
    logic prev_p2;

    // Metastability pair plus the previous-level flop used for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_p0 <= RESET_VAL;
            sync_p1 <= RESET_VAL;
            prev_p2 <= RESET_VAL;
        end else begin
            meta_p0 <= d;
            sync_p1 <= meta_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign level = sync_p1;
    assign rise  = sync_p1 & ~prev_p2;
    assign fall  = ~sync_p1 & prev_p2;

endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 peripheral in front of NUM_REGS x DATA_W config
// registers. A frame is only committed when nCS rises after exactly
// FRAME_BITS SCLK edges; anything else is dropped with a frame_err pulse.
// Optional build macro SPI_READBACK_EN drives register contents on CIPO
// during the data phase of read frames; without it CIPO is tied low.
module spi_reg_bank
    import spi_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       spi_ncs,
    input  logic                       spi_copi,
    input  logic                       spi_sclk,
    output logic                       spi_cipo,
    output logic                       spi_cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int FRAME_BITS = frame_bits(ADDR_W, DATA_W);
    localparam int CNT_W      = $clog2(FRAME_BITS + 2);
    localparam int RW_POS     = rw_pos(ADDR_W, DATA_W);
    localparam int ADDR_LSB   = addr_lsb(DATA_W);

    localparam logic [CNT_W-1:0]  CNT_FULL     = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]  CNT_SAT      = CNT_W'(FRAME_BITS + 1);
    localparam logic [ADDR_W:0]   NUM_REGS_LIM = (ADDR_W + 1)'(NUM_REGS);

    // Synchronised pin views.
    logic ncs_level, ncs_rise, ncs_fall;
    logic sclk_rise, sclk_fall, sclk_level_unused;
    logic copi_level, copi_rise_unused, copi_fall_unused;

    spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_ncs (
        .clk   (clk),
        .rst   (rst),
        .d     (spi_ncs),
        .level (ncs_level),
        .rise  (ncs_rise),
        .fall  (ncs_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk   (clk),
        .rst   (rst),
        .d     (spi_sclk),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_copi (
        .clk   (clk),
        .rst   (rst),
        .d     (spi_copi),
        .level (copi_level),
        .rise  (copi_rise_unused),
        .fall  (copi_fall_unused)
    );

    // Arming: the ncs synchroniser needs two clocks after reset before its
    // level reflects the pin. A frame may only start once nCS has been seen
    // high with valid samples, so a frame already in flight at reset release
    // is ignored until nCS goes high and low again.
    logic [1:0] settle_q;
    logic       armed_q;

    // Count out the synchroniser fill time, then latch nCS-seen-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_q <= 2'd0;
            armed_q  <= 1'b0;
        end else begin
            if (settle_q != 2'd2) begin
                settle_q <= settle_q + 2'd1;
            end
            if (settle_q == 2'd2 && ncs_level) begin
                armed_q <= 1'b1;
            end
        end
    end

    // Frame FSM.
    state_t state_q, state_d;
    logic   shift_en;
    logic   frame_clr;
    logic   do_commit;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath enables; an ncs rise beats a same-cycle SCLK rise.
    always_comb begin
        state_d   = state_q;
        shift_en  = 1'b0;
        frame_clr = 1'b0;
        do_commit = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ncs_fall && armed_q) begin
                    state_d   = ACTIVE;
                    frame_clr = 1'b1;
                end
            end
            ACTIVE: begin
                if (ncs_rise) begin
                    state_d = COMMIT;
                end else if (sclk_rise) begin
                    shift_en = 1'b1;
                end
            end
            COMMIT: begin
                do_commit = 1'b1;
                frame_clr = 1'b1;
                state_d   = ncs_fall ? ACTIVE : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Receive shift register and saturating bit counter.
    logic [FRAME_BITS-1:0] sr_q;
    logic [CNT_W-1:0]      cnt_q;

    // Shift COPI in MSB first; counter stops at FRAME_BITS+1 so long frames stay flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (frame_clr) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (shift_en) begin
            sr_q <= {sr_q[FRAME_BITS-2:0], copi_level};
            if (cnt_q != CNT_SAT) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Decoded fields of a completed frame.
    logic              fr_rw;
    logic [ADDR_W-1:0] fr_addr;
    logic [DATA_W-1:0] fr_data;
    logic              len_ok;
    logic              in_range;
    logic              wr_hit;
    logic              len_bad;

    assign fr_rw    = sr_q[RW_POS];
    assign fr_addr  = sr_q[ADDR_LSB +: ADDR_W];
    assign fr_data  = sr_q[DATA_W-1:0];
    assign len_ok   = (cnt_q == CNT_FULL);
    assign in_range = ({1'b0, fr_addr} < NUM_REGS_LIM);
    assign wr_hit   = do_commit && len_ok && (fr_rw == RW_WRITE) && in_range;
    assign len_bad  = do_commit && !len_ok;

    // Register bank.
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Commit a well-formed in-range write and emit the single-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            wr_addr   <= '0;
        end else begin
            wr_strobe <= wr_hit;
            frame_err <= len_bad;
            if (wr_hit) begin
                wr_addr <= fr_addr;
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (fr_addr == ADDR_W'(k)) begin
                        regs_q[k] <= fr_data;
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
        assign regs_o[k*DATA_W +: DATA_W] = regs_q[k];
    end

`ifdef SPI_READBACK_EN
    localparam logic [CNT_W-1:0] CNT_HDR       = CNT_W'(hdr_bits(ADDR_W));
    localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ADDR_W);

    logic [FRAME_BITS-1:0] sr_next;
    logic                  hdr_done;
    logic [ADDR_W-1:0]     hdr_addr;
    logic                  rd_load;
    logic                  tx_shift;
    logic [DATA_W-1:0]     rd_data;
    logic [DATA_W-1:0]     tx_q;
    logic                  oe_q;

    // Header is complete on the SCLK rise that brings in the last address bit.
    assign sr_next  = {sr_q[FRAME_BITS-2:0], copi_level};
    assign hdr_done = shift_en && (cnt_q == CNT_ADDR_LAST);
    assign hdr_addr = sr_next[ADDR_W-1:0];
    assign rd_load  = hdr_done && (sr_next[ADDR_W] != RW_WRITE);
    // The falling edge right after the load is skipped so the controller
    // samples the MSB on the first data-phase rise.
    assign tx_shift = oe_q && sclk_fall && (cnt_q > CNT_HDR);

    // Read mux; unimplemented addresses return zero.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (hdr_addr == ADDR_W'(k)) begin
                rd_data = regs_q[k];
            end
        end
    end

    // Transmit shift register; output enable holds from load until COMMIT ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q <= '0;
            oe_q <= 1'b0;
        end else if (state_q == COMMIT) begin
            tx_q <= '0;
            oe_q <= 1'b0;
        end else if (rd_load) begin
            tx_q <= rd_data;
            oe_q <= 1'b1;
        end else if (tx_shift) begin
            tx_q <= {tx_q[DATA_W-2:0], 1'b0};
        end
    end

    assign spi_cipo    = tx_q[DATA_W-1];
    assign spi_cipo_oe = oe_q;
`else
    logic sclk_fall_unused;

    assign sclk_fall_unused = sclk_fall;
    assign spi_cipo         = 1'b0;
    assign spi_cipo_oe      = 1'b0;
`endif

endmodule
